demux_1_3_reg: RTL

//  Registered 1-to-3 demultiplexer: the inverse of the datapath's 3:1 source muxes.
//  One producer word is steered, by a 2-bit select, to one of three destination ports.

---
 rtl/mc_pkg.sv | 15 +
 rtl/demux_slot.sv | 57 +++++
 rtl/demux_1_3_reg.sv | 104 ++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared datapath definitions: destination select codes used by the 3:1 muxes
// and the 1:3 demux, plus the holding-slot state encoding.
package mc_pkg;

   localparam logic [1:0] SEL_D0  = 2'd0;
   localparam logic [1:0] SEL_D1  = 2'd1;
   localparam logic [1:0] SEL_D2  = 2'd2;
   localparam logic [1:0] SEL_BAD = 2'd3;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage : mc_pkg

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready handshake; written by the demux,
// drained by a single consumer.
module demux_slot
   import mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // NOTE: defaults first, so no path through the case leaves a variable unassigned (no latch).
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      unique case (state_q)
         SLOT_EMPTY: begin
            if (wr_en) begin
               state_d = SLOT_FULL;
               data_d  = wr_data;
            end
         end
         SLOT_FULL: begin
            // A write while full is only possible when the consumer drains this cycle.
            if (wr_en) begin
               data_d = wr_data;
            end else if (rd_ready) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   assign valid = (state_q == SLOT_FULL);
   assign data  = data_q;

endmodule : demux_slot

// File: rtl/demux_1_3_reg.sv
// Registered 1-to-3 demultiplexer between the ALU-result stage and write-back consumers.
// Define DEMUX_CNT_EN to add per-destination consume counters cnt0/cnt1/cnt2.
module demux_1_3_reg
   import mc_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           select,
   input  logic [WIDTH-1:0]     in_data,
   output logic [2:0]           out_valid,
   input  logic [2:0]           out_ready,
   output logic [WIDTH-1:0]     out_data0,
   output logic [WIDTH-1:0]     out_data1,
   output logic [WIDTH-1:0]     out_data2,
   output logic                 err_illegal
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] cnt0,
   output logic [CNT_WIDTH-1:0] cnt1,
   output logic [CNT_WIDTH-1:0] cnt2
`endif
);

   logic             accept;
   logic [2:0]       wr_en;
   logic [WIDTH-1:0] slot_data [3];
   logic             err_illegal_q;

   // in_ready deliberately ignores in_valid so the producer can look before it leaps.
   always_comb begin
      in_ready = 1'b1;
      unique case (select)
         SEL_D0:  in_ready = !out_valid[0] || out_ready[0];
         SEL_D1:  in_ready = !out_valid[1] || out_ready[1];
         SEL_D2:  in_ready = !out_valid[2] || out_ready[2];
         default: in_ready = 1'b1;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      wr_en = 3'b000;
      unique case (select)
         SEL_D0:  wr_en[0] = accept;
         SEL_D1:  wr_en[1] = accept;
         SEL_D2:  wr_en[2] = accept;
         default: wr_en    = 3'b000;
      endcase
   end

   for (genvar i = 0; i < 3; i++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_en[i]),
         .wr_data  (in_data),
         .rd_ready (out_ready[i]),
         .valid    (out_valid[i]),
         .data     (slot_data[i])
      );
   end

   assign out_data0 = slot_data[0];
   assign out_data1 = slot_data[1];
   assign out_data2 = slot_data[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_illegal_q <= 1'b0;
      end else begin
         err_illegal_q <= accept && (select == SEL_BAD);
      end
   end

   assign err_illegal = err_illegal_q;

`ifdef DEMUX_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q [3];

   // NOTE: the counter array is small state with a defined reset value, so it is reset like any flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (out_valid[i] && out_ready[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
`endif

endmodule : demux_1_3_reg
